// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and helper functions for the Rijndael round datapath.
//   shift_off(nb, r)          : ShiftRows row offset C_r for an Nb-column block
//   shift_rows(state, nb, inv): ShiftRows (inv=0) / InvShiftRows (inv=1) on a
//                               state of up to MAX_BW bits, byte k at
//                               state[8k +: 8], column-major (k = 4*c + r).
// States narrower than MAX_BW occupy indices [0 : 32*nb-1]; the rest is ignored.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int ROWS   = 4;
  localparam int BYTE_W = 8;
  localparam int MAX_NB = 8;
  localparam int MAX_BW = ROWS * BYTE_W * MAX_NB;

  // Row offsets: row 0 never moves; 256-bit blocks use the wider 3/4 spacing.
  function automatic logic [2:0] shift_off(input int nb, input int r);
    logic [2:0] off;
    case (r)
      32'sd0:  off = 3'd0;
      32'sd1:  off = 3'd1;
      32'sd2:  off = (nb == 32'sd8) ? 3'd3 : 3'd2;
      32'sd3:  off = (nb == 32'sd8) ? 3'd4 : 3'd3;
      default: off = 3'd0;
    endcase
    return off;
  endfunction

  // Pure byte rewiring; with a constant nb this folds to wires.
  function automatic logic [0:MAX_BW-1] shift_rows(input logic [0:MAX_BW-1] state,
                                                   input int nb, input logic inv);
    logic [0:MAX_BW-1] res;
    int                src;
    res = '0;
    for (int c = 0; c < MAX_NB; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (c < nb) begin
          if (inv) src = (c - int'(shift_off(nb, r)) + nb) % nb;
          else     src = (c + int'(shift_off(nb, r))) % nb;
          res[BYTE_W*(ROWS*c + r) +: BYTE_W] = state[BYTE_W*(ROWS*src + r) +: BYTE_W];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_pipe_slot.sv
// -----------------------------------------------------------------------------
// aes_pipe_slot
// One valid/ready register slot: holds a W-bit payload plus a valid bit.
//   clk, rst      : clock, synchronous active-high reset (valid and data to 0)
//   clr           : synchronous flush of the valid bit; payload is kept
//   up_valid/up_data/up_ready : upstream side
//   dn_valid/dn_data/dn_ready : downstream side (dn_* driven by registers)
// The slot can take a new payload when empty or when its content leaves this
// cycle, so a chain of slots sustains one transfer per cycle without bubbles.
// -----------------------------------------------------------------------------
module aes_pipe_slot #(
  parameter int W = 129
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready,
  output logic         dn_valid,
  output logic [W-1:0] dn_data,
  input  logic         dn_ready
);

  logic         v_q, v_d;
  logic [W-1:0] data_q, data_d;

  assign up_ready = ~v_q | dn_ready;
  assign dn_valid = v_q;
  assign dn_data  = data_q;

  // Next-state: flush drops the valid bit; payload only loads on an accept,
  // which keeps the output stable while stalled.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (clr) begin
      v_d = 1'b0;
    end else if (up_ready) begin
      v_d = up_valid;
      if (up_valid) data_d = up_data;
      else          data_d = data_q;
    end else begin
      v_d = v_q;
    end
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// aes_shift_rows_pipe
// Rijndael ShiftRows / InvShiftRows stage with per-block mode and a STAGES-deep
// valid/ready pipeline.
//   clk, rst             : clock, synchronous active-high reset
//   flush                : drop all in-flight blocks (data and blk_cnt kept)
//   in_valid/in_ready    : input handshake; in_ready is 0 during rst or flush
//   in_inv, in_data      : mode (1 = inverse) and state, byte k = in_data[8k +: 8]
//   out_valid/out_ready  : output handshake, out_valid from registers
//   out_inv, out_data    : mode and permuted state of the output block
//   busy                 : some slot holds a valid block
//   blk_cnt              : delivered-block count, wraps
// The permutation is applied before slot 0; later slots just carry payload.
// -----------------------------------------------------------------------------
module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [0:32*NB-1]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_inv,
  output logic [0:32*NB-1]  out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  blk_cnt
);

  localparam int BW = ROWS * BYTE_W * NB;
  localparam int W  = BW + 1;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("aes_shift_rows_pipe: STAGES must be 1..4");
  end

  logic [0:BW-1]      perm_s;
  logic               v_s [0:STAGES];
  logic               r_s [0:STAGES];
  logic [W-1:0]       d_s [0:STAGES];
  logic               busy_s;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

  // Byte rewiring. The block is left-aligned into the MAX_BW-wide helper
  // (index 0 is the MSB) and the result is right-shifted back down.
  always_comb begin
    perm_s = BW'(shift_rows(MAX_BW'(in_data) << (MAX_BW - BW), NB, in_inv) >> (MAX_BW - BW));
  end

  assign v_s[0]      = in_valid;
  assign d_s[0]      = {in_inv, perm_s};
  assign r_s[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    aes_pipe_slot #(.W(W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .up_valid (v_s[i]),
      .up_data  (d_s[i]),
      .up_ready (r_s[i]),
      .dn_valid (v_s[i+1]),
      .dn_data  (d_s[i+1]),
      .dn_ready (r_s[i+1])
    );
  end

  // Any slot occupied.
  always_comb begin
    busy_s = 1'b0;
    for (int i = 1; i <= STAGES; i++) busy_s = busy_s | v_s[i];
  end

  assign in_ready  = r_s[0] & ~flush & ~rst;
  assign out_valid = v_s[STAGES];
  assign out_inv   = d_s[STAGES][W-1];
  assign out_data  = d_s[STAGES][BW-1:0];
  assign busy      = busy_s;
  assign blk_cnt   = blk_cnt_q;

  // Count delivered blocks; a flush cycle counts nothing.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (!flush && out_valid && out_ready) blk_cnt_d = blk_cnt_q + CNT_W'(1);
    else                                  blk_cnt_d = blk_cnt_q;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) blk_cnt_q <= '0;
    else     blk_cnt_q <= blk_cnt_d;
  end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
module tb_aes_shift_rows_pipe;

  localparam int A_STAGES = 2;
  localparam int B_STAGES = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: NB=4, STAGES=2
  logic         a_flush = 1'b0, a_in_valid = 1'b0, a_in_inv = 1'b0, a_out_ready = 1'b0;
  logic         a_in_ready, a_out_valid, a_out_inv, a_busy;
  logic [0:127] a_in_data = '0;
  logic [0:127] a_out_data;
  logic [31:0]  a_blk_cnt;

  // Instance B: NB=8, STAGES=1
  logic         b_flush = 1'b0, b_in_valid = 1'b0, b_in_inv = 1'b0, b_out_ready = 1'b0;
  logic         b_in_ready, b_out_valid, b_out_inv, b_busy;
  logic [0:255] b_in_data = '0;
  logic [0:255] b_out_data;
  logic [31:0]  b_blk_cnt;

  aes_shift_rows_pipe #(.NB(4), .STAGES(A_STAGES), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_inv(a_in_inv), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_inv(a_out_inv), .out_data(a_out_data), .busy(a_busy), .blk_cnt(a_blk_cnt));

  aes_shift_rows_pipe #(.NB(8), .STAGES(B_STAGES), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inv(b_in_inv), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_inv(b_out_inv), .out_data(b_out_data), .busy(b_busy), .blk_cnt(b_blk_cnt));

  int n_pass = 0;
  int n_total = 0;

  // Reference: each row is a list of NB bytes rotated left (forward) or right
  // (inverse) by its offset.
  function automatic logic [0:255] ref_shift(input logic [0:255] d, input int nb, input bit inv);
    logic [0:255] o;
    byte unsigned row[$];
    int off;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      off = (r == 0) ? 0 : ((nb == 8 && r > 1) ? r + 1 : r);
      row = {};
      for (int c = 0; c < nb; c++) row.push_back(d[8*(4*c+r) +: 8]);
      repeat (off) begin
        if (inv) row.push_front(row.pop_back());
        else     row.push_back(row.pop_front());
      end
      for (int c = 0; c < nb; c++) o[8*(4*c+r) +: 8] = row[c];
    end
    return o;
  endfunction

  function automatic logic [0:127] ref4(input logic [0:127] d, input bit inv);
    logic [0:255] t;
    t = '0;
    t[0:127] = d;
    t = ref_shift(t, 4, inv);
    return t[0:127];
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Push one block into an empty A and wait (bounded) for it at the output.
  task automatic a_send_wait(input logic [0:127] d, input logic inv, output int lat,
                             output logic [0:127] od, output logic oi);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = d; a_in_inv = inv; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      lat++;
      @(negedge clk);
      if (a_out_valid) break;
      @(posedge clk);
    end
    od = a_out_data;
    oi = a_out_inv;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (a_in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", a_in_ready); else n_pass++;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", a_out_valid); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", a_busy); else n_pass++;
    n_total++; if (a_blk_cnt !== 32'd0) $display("FAIL rst_blk_cnt got=%0d exp=0", a_blk_cnt); else n_pass++;
    n_total++; if (a_out_data !== 128'd0) $display("FAIL rst_out_data got=%h exp=0", a_out_data); else n_pass++;
    n_total++; if (a_out_inv !== 1'b0) $display("FAIL rst_out_inv got=%b exp=0", a_out_inv); else n_pass++;
    n_total++; if (b_out_valid !== 1'b0) $display("FAIL rst_b_out_valid got=%b exp=0", b_out_valid); else n_pass++;
    rst = 1'b0; a_in_valid = 1'b0;
  endtask

  task automatic test_vectors();
    logic [0:127] v_in, v_out, od;
    logic oi;
    int lat;
    v_in  = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    v_out = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    a_send_wait(v_in, 1'b0, lat, od, oi);
    n_total++; if (lat !== A_STAGES) $display("FAIL fwd_latency got=%0d exp=%0d", lat, A_STAGES); else n_pass++;
    n_total++; if (od !== v_out) $display("FAIL fwd_vector got=%h exp=%h", od, v_out); else n_pass++;
    n_total++; if (od !== ref4(v_in, 1'b0)) $display("FAIL fwd_model got=%h exp=%h", od, ref4(v_in, 1'b0)); else n_pass++;
    n_total++; if (oi !== 1'b0) $display("FAIL fwd_out_inv got=%b exp=0", oi); else n_pass++;
    a_send_wait(v_out, 1'b1, lat, od, oi);
    n_total++; if (lat !== A_STAGES) $display("FAIL inv_latency got=%0d exp=%0d", lat, A_STAGES); else n_pass++;
    n_total++; if (od !== v_in) $display("FAIL inv_vector got=%h exp=%h", od, v_in); else n_pass++;
    n_total++; if (oi !== 1'b1) $display("FAIL inv_out_inv got=%b exp=1", oi); else n_pass++;
    @(negedge clk);
    n_total++; if (a_blk_cnt !== 32'd2) $display("FAIL vec_blk_cnt got=%0d exp=2", a_blk_cnt); else n_pass++;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL vec_drained got=%b exp=0", a_out_valid); else n_pass++;
  endtask

  task automatic test_nb8();
    logic [0:255] orig, res;
    for (int k = 0; k < 32; k++) orig[8*k +: 8] = 8'(k);
    @(negedge clk);
    b_in_data = orig; b_in_inv = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    res = b_out_data;
    n_total++; if (b_out_valid !== 1'b1) $display("FAIL nb8_latency out_valid got=%b exp=1", b_out_valid); else n_pass++;
    n_total++; if (res[8 +: 8] !== 8'h05) $display("FAIL nb8_byte1 got=%h exp=05", res[8 +: 8]); else n_pass++;
    n_total++; if (res[16 +: 8] !== 8'h0e) $display("FAIL nb8_byte2 got=%h exp=0e", res[16 +: 8]); else n_pass++;
    n_total++; if (res[24 +: 8] !== 8'h13) $display("FAIL nb8_byte3 got=%h exp=13", res[24 +: 8]); else n_pass++;
    // byte 6 is row 2, column 1: taken from column 1+3 = 4, i.e. byte 18.
    n_total++; if (res[48 +: 8] !== 8'h12) $display("FAIL nb8_byte6 got=%h exp=12", res[48 +: 8]); else n_pass++;
    n_total++; if (res !== ref_shift(orig, 8, 1'b0)) $display("FAIL nb8_fwd got=%h exp=%h", res, ref_shift(orig, 8, 1'b0)); else n_pass++;
    b_in_data = res; b_in_inv = 1'b1; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    n_total++; if (b_out_data !== orig) $display("FAIL nb8_inv_restore got=%h exp=%h", b_out_data, orig); else n_pass++;
    n_total++; if (b_out_inv !== 1'b1) $display("FAIL nb8_inv_mode got=%b exp=1", b_out_inv); else n_pass++;
  endtask

  task automatic test_stall();
    logic [0:127] blk [4];
    logic         inv [4];
    logic [0:127] held;
    bit seen, stable;
    int acc, got, cyc;
    for (int i = 0; i < 4; i++) begin blk[i] = rnd128(); inv[i] = 1'($urandom_range(0, 1)); end
    apply_reset();
    acc = 0; seen = 0; stable = 1; held = '0;
    a_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a_in_valid = 1'b1; a_in_data = blk[acc]; a_in_inv = inv[acc];
      #1;
      if (a_out_valid) begin
        if (!seen) begin held = a_out_data; seen = 1; end
        else if (a_out_data !== held) stable = 0;
      end
      if (a_in_ready) acc++;
    end
    n_total++; if (acc !== 2) $display("FAIL stall_accepted got=%0d exp=2", acc); else n_pass++;
    n_total++; if (a_in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b exp=0", a_in_ready); else n_pass++;
    n_total++; if (a_out_valid !== 1'b1) $display("FAIL stall_out_valid got=%b exp=1", a_out_valid); else n_pass++;
    n_total++; if (stable !== 1'b1) $display("FAIL stall_stable got=%b exp=1", stable); else n_pass++;
    n_total++; if (a_out_data !== ref4(blk[0], inv[0])) $display("FAIL stall_head got=%h exp=%h", a_out_data, ref4(blk[0], inv[0])); else n_pass++;
    n_total++; if (a_busy !== 1'b1) $display("FAIL stall_busy got=%b exp=1", a_busy); else n_pass++;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 30) begin
      @(negedge clk);
      a_out_ready = 1'b1;
      a_in_valid = (acc < 4);
      if (acc < 4) begin a_in_data = blk[acc]; a_in_inv = inv[acc]; end
      #1;
      if (a_out_valid) begin
        n_total++;
        if (a_out_data !== ref4(blk[got], inv[got]) || a_out_inv !== inv[got])
          $display("FAIL stall_order blk%0d got=%h/%b exp=%h/%b", got, a_out_data, a_out_inv, ref4(blk[got], inv[got]), inv[got]);
        else n_pass++;
        got++;
      end
      if (a_in_valid && a_in_ready) acc++;
      cyc++;
    end
    a_in_valid = 1'b0;
    n_total++; if (got !== 4) $display("FAIL stall_delivered got=%0d exp=4", got); else n_pass++;
    @(negedge clk);
    n_total++; if (a_blk_cnt !== 32'd4) $display("FAIL stall_blk_cnt got=%0d exp=4", a_blk_cnt); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL stall_idle got=%b exp=0", a_busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [0:127] blk [8];
    int acc, got, cyc, first;
    for (int i = 0; i < 8; i++) blk[i] = rnd128();
    acc = 0; got = 0; cyc = 0; first = -1;
    a_out_ready = 1'b1;
    while (got < 8 && cyc < 40) begin
      @(negedge clk);
      a_in_valid = (acc < 8);
      if (acc < 8) begin a_in_data = blk[acc]; a_in_inv = acc[0]; end
      #1;
      if (acc < 8) begin
        n_total++; if (a_in_ready !== 1'b1) $display("FAIL b2b_in_ready cyc%0d got=%b exp=1", cyc, a_in_ready); else n_pass++;
      end
      if (a_out_valid) begin
        if (first < 0) first = cyc;
        n_total++;
        if (a_out_data !== ref4(blk[got], got[0]) || a_out_inv !== got[0])
          $display("FAIL b2b_data blk%0d got=%h/%b exp=%h/%b", got, a_out_data, a_out_inv, ref4(blk[got], got[0]), got[0]);
        else n_pass++;
        got++;
      end
      if (a_in_valid && a_in_ready) acc++;
      cyc++;
    end
    a_in_valid = 1'b0;
    n_total++; if (first !== A_STAGES) $display("FAIL b2b_first_out got=%0d exp=%0d", first, A_STAGES); else n_pass++;
    n_total++; if (cyc - first !== 8) $display("FAIL b2b_throughput got=%0d exp=8", cyc - first); else n_pass++;
  endtask

  // Fill A with two blocks while stalled.
  task automatic fill_two(input logic [0:127] b0, input logic [0:127] b1);
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = b0; a_in_inv = 1'b0;
    @(negedge clk);
    a_in_data = b1;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic test_flush();
    logic [0:127] b0, b1, b2, od;
    logic oi;
    int lat, cnt0;
    bit leaked;
    b0 = rnd128(); b1 = rnd128(); b2 = rnd128();
    @(negedge clk);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = b2; a_out_ready = 1'b1;
    #1;
    n_total++; if (a_in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b exp=0", a_in_ready); else n_pass++;
    @(negedge clk);
    a_flush = 1'b0; a_in_valid = 1'b0;
    n_total++; if (a_busy !== 1'b0) $display("FAIL flush_no_accept got=%b exp=0", a_busy); else n_pass++;
    fill_two(b0, b1);
    a_flush = 1'b1;
    cnt0 = a_blk_cnt;
    @(negedge clk);
    a_flush = 1'b0; a_out_ready = 1'b1;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL flush_out_valid got=%b exp=0", a_out_valid); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL flush_busy got=%b exp=0", a_busy); else n_pass++;
    n_total++; if (a_out_data !== ref4(b0, 1'b0)) $display("FAIL flush_data_kept got=%h exp=%h", a_out_data, ref4(b0, 1'b0)); else n_pass++;
    n_total++; if (a_blk_cnt !== 32'(cnt0)) $display("FAIL flush_blk_cnt got=%0d exp=%0d", a_blk_cnt, cnt0); else n_pass++;
    leaked = 0;
    repeat (4) begin @(negedge clk); if (a_out_valid) leaked = 1; end
    n_total++; if (leaked !== 1'b0) $display("FAIL flush_leak got=%b exp=0", leaked); else n_pass++;
    a_send_wait(b2, 1'b1, lat, od, oi);
    n_total++; if (lat !== A_STAGES) $display("FAIL flush_next_latency got=%0d exp=%0d", lat, A_STAGES); else n_pass++;
    n_total++; if (od !== ref4(b2, 1'b1)) $display("FAIL flush_next_data got=%h exp=%h", od, ref4(b2, 1'b1)); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [0:127] b0, b1, b2, od;
    logic oi;
    int lat;
    bit leaked;
    b0 = rnd128(); b1 = rnd128(); b2 = rnd128();
    fill_two(b0, b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_out_ready = 1'b1;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL mrst_out_valid got=%b exp=0", a_out_valid); else n_pass++;
    n_total++; if (a_busy !== 1'b0) $display("FAIL mrst_busy got=%b exp=0", a_busy); else n_pass++;
    n_total++; if (a_blk_cnt !== 32'd0) $display("FAIL mrst_blk_cnt got=%0d exp=0", a_blk_cnt); else n_pass++;
    n_total++; if (a_out_data !== 128'd0) $display("FAIL mrst_out_data got=%h exp=0", a_out_data); else n_pass++;
    leaked = 0;
    repeat (4) begin @(negedge clk); if (a_out_valid) leaked = 1; end
    n_total++; if (leaked !== 1'b0) $display("FAIL mrst_leak got=%b exp=0", leaked); else n_pass++;
    a_send_wait(b2, 1'b0, lat, od, oi);
    n_total++; if (lat !== A_STAGES) $display("FAIL mrst_next_latency got=%0d exp=%0d", lat, A_STAGES); else n_pass++;
    n_total++; if (od !== ref4(b2, 1'b0)) $display("FAIL mrst_next_data got=%h exp=%h", od, ref4(b2, 1'b0)); else n_pass++;
    @(negedge clk);
    n_total++; if (a_blk_cnt !== 32'd1) $display("FAIL mrst_count_after got=%0d exp=1", a_blk_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_nb8();
    test_stall();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
